mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: req_valid  in  1  CPU requests an access; sampled only in IDLE.
REQ-004 SHALL have: req_op  in  4  mem_op_t (LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW).
REQ-005 SHALL have: req_addr  in  32  byte address; req_wdata  in  32  store data (rt); req_rt  in  32  old rt value, used by the LWL/LWR merge.
REQ-006 SHALL have: busy  out  1  high whenever state != IDLE.
REQ-007 SHALL have: done  out  1  one-cycle completion pulse; rdata  out  32  load result, valid when done=1.
REQ-008 SHALL have: addr_err  out  1  misaligned or illegal op; valid when done=1.
REQ-009 SHALL have bus ports: mem_address out 32; mem_read out 1; mem_write out 1; mem_byteenable out 4; mem_writedata out 32; mem_readdata in 32; mem_waitrequest in 1.

Function
REQ-010 SHALL use states IDLE, ACCESS, RESP.
REQ-011 IDLE: when req_valid=1, SHALL register op, addr, wdata and rt, then go to ACCESS. A legal, aligned request SHALL cause a bus access. A misaligned or illegal request SHALL go to RESP instead.
REQ-012 ACCESS: SHALL assert mem_read (loads) or mem_write (stores), never both. mem_address SHALL be {addr[31:2],2'b00}. All bus outputs SHALL be held stable while mem_waitrequest=1.
REQ-013 ACCESS with mem_waitrequest=0: SHALL capture mem_readdata (loads), deassert read/write on the next edge, and go to RESP.
REQ-014 RESP: SHALL assert done=1 for exactly one cycle, then return to IDLE. No-wait latency is request cycle N, done at N+2.
REQ-015 req_valid while busy=1 SHALL be ignored; the requester holds the request until done.
REQ-016 Byte lane k = addr[1:0] SHALL occupy bits [8k+7:8k] (little-endian).
REQ-017 Misalignment SHALL be defined as: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Such a request SHALL set addr_err=1 and rdata=0, and SHALL perform no bus access.
REQ-018 Stores SHALL drive:
  - SB: byteenable 1<<k, writedata {4{wdata[7:0]}}.
  - SH: byteenable addr[1] ? 4'b1100 : 4'b0011, writedata {2{wdata[15:0]}}.
  - SW: byteenable 4'b1111, writedata wdata.
REQ-019 Loads SHALL drive byteenable 4'b1111.
REQ-020 Loads SHALL produce:
  - LB: selected byte, sign-extended. LBU: selected byte, zero-extended.
  - LH: selected halfword, sign-extended. LHU: selected halfword, zero-extended.
  - LW: whole word.
REQ-021 LWL (k = addr[1:0]) SHALL place memory bytes k..0 into rt bytes 3..3-k and keep the remaining rt bytes. k=3 SHALL yield the full word.
REQ-022 LWR (k = addr[1:0]) SHALL place memory bytes 3..k into rt bytes 3-k..0 and keep the remaining rt bytes. k=0 SHALL yield the full word.
REQ-023 Stores SHALL return rdata=0.

Reset
REQ-024 Reset SHALL force state to IDLE and drive all outputs to 0, including busy, done, mem_read, mem_write, mem_byteenable and mem_address.
REQ-025 Reset asserted in ACCESS SHALL deassert mem_read/mem_write at that edge. No done pulse SHALL be issued for the aborted request.

Configuration
REQ-026 With UNALIGNED_LWL_LWR_EN defined, LWL and LWR SHALL behave per REQ-021 and REQ-022.
REQ-027 Without UNALIGNED_LWL_LWR_EN, LWL and LWR SHALL be treated as illegal: addr_err=1, no bus access, and the merge logic SHALL be absent.

Structure
REQ-028 mem_op_t and the byteenable constants SHALL live in shared package mips_mem_pkg.
REQ-029 Load extraction and the LWL/LWR merge SHALL be a combinational sub-module, load_align (inputs: word, op, k, rt; output: result).

Verification
REQ-030 LB: addr 0x1003, readdata 0x80AB_CD12, no wait -> done at N+2, rdata 0xFFFF_FF80, addr_err 0.
REQ-031 SH: addr 0x2002, wdata 0x0000_BEEF, waitrequest high for 3 cycles -> byteenable 4'b1100, writedata 0xBEEF_BEEF, outputs stable while waiting, done 1 cycle after waitrequest falls.
REQ-032 LW: addr 0x3001 -> no mem_read ever asserted, done at N+2, addr_err 1, rdata 0.
REQ-033 LWL: addr 0x4001, readdata 0x4433_2211, rt 0xAAAA_AAAA -> rdata 0x2211_AAAA (macro defined); addr_err 1 (macro undefined).
REQ-034 Reset mid-access: reset during ACCESS with waitrequest held high -> mem_read 0 after the edge, no done pulse, busy 0; the next request completes normally.
REQ-035 req_valid pulsed while busy -> ignored; exactly one done per accepted request.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared memory-op encoding, byte-enable constants and request helpers
// used by the MIPS memory access controller and its load aligner.
package mips_mem_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd7,
    OP_SH  = 4'd8,
    OP_SW  = 4'd9
  } mem_op_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic op_is_load(input logic [3:0] op);
    logic r;
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    logic r;
    case (op)
      OP_SB, OP_SH, OP_SW: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] a);
    logic r;
    case (op)
      OP_LH, OP_LHU, OP_SH: r = a[0];
      OP_LW, OP_SW:         r = |a;
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_byteenable(input logic [3:0] op, input logic [1:0] k);
    logic [3:0] r;
    case (op)
      OP_SB:   r = 4'b0001 << k;
      OP_SH:   r = k[1] ? BE_HI_HALF : BE_LO_HALF;
      OP_SW:   r = BE_WORD;
      default: r = BE_NONE;
    endcase
    return r;
  endfunction

  // Replicate store data across lanes so the byteenable alone selects the target bytes.
  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wdata);
    logic [31:0] r;
    case (op)
      OP_SB:   r = {4{wdata[7:0]}};
      OP_SH:   r = {2{wdata[15:0]}};
      OP_SW:   r = wdata;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Combinational load extraction (byte/half/word) plus the LWL/LWR merge with
// the old rt value; the merge exists only when UNALIGNED_LWL_LWR_EN is defined.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  op,
  input  logic [1:0]  k,
  input  logic [31:0] rt,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = word[{k, 3'b000} +: 8];
  assign sel_half = k[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = '0;
    case (op)
      OP_LB:  result = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU: result = {24'h0, sel_byte};
      OP_LH:  result = {{16{sel_half[15]}}, sel_half};
      OP_LHU: result = {16'h0, sel_half};
      OP_LW:  result = word;
`ifdef UNALIGNED_LWL_LWR_EN
      // LWL fills rt from the top down with memory bytes k..0.
      OP_LWL: begin
        case (k)
          2'd0:    result = {word[7:0],  rt[23:0]};
          2'd1:    result = {word[15:0], rt[15:0]};
          2'd2:    result = {word[23:0], rt[7:0]};
          default: result = word;
        endcase
      end
      // LWR fills rt from the bottom up with memory bytes 3..k.
      OP_LWR: begin
        case (k)
          2'd0:    result = word;
          2'd1:    result = {rt[31:24], word[31:8]};
          2'd2:    result = {rt[31:16], word[31:16]};
          default: result = {rt[31:8],  word[31:24]};
        endcase
      end
`endif
      default: result = '0;
    endcase
  end

`ifndef UNALIGNED_LWL_LWR_EN
  logic unused_rt;
  assign unused_rt = ^rt;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side memory access controller driving an Avalon-style bus with waitrequest.
// Define UNALIGNED_LWL_LWR_EN to support LWL/LWR; otherwise they are rejected as illegal.
//
// state     | meaning
// ST_IDLE   | waiting for req_valid; request fields captured on acceptance
// ST_ACCESS | bus read/write held until waitrequest drops (idle bus if rejected)
// ST_RESP   | done pulse with rdata/addr_err, then back to idle
module mem_access_ctrl
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

`ifdef UNALIGNED_LWL_LWR_EN
  localparam logic LWLR_EN = 1'b1;
`else
  localparam logic LWLR_EN = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] rt_q, rt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;

  logic        req_bad;
  logic        req_lwlr;
  logic [31:0] align_result;

  load_align u_load_align (
    .word   (mem_readdata),
    .op     (op_q),
    .k      (k_q),
    .rt     (rt_q),
    .result (align_result)
  );

  always_comb begin
    req_lwlr = (req_op == OP_LWL) || (req_op == OP_LWR);
    req_bad  = !(op_is_load(req_op) || op_is_store(req_op))
             || op_misaligned(req_op, req_addr[1:0])
             || (!LWLR_EN && req_lwlr);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    k_d     = k_q;
    rt_d    = rt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_ACCESS;
          op_d    = req_op;
          k_d     = req_addr[1:0];
          rt_d    = req_rt;
          err_d   = req_bad;
          rdata_d = '0;
          if (!req_bad) begin
            rd_d   = op_is_load(req_op);
            wr_d   = op_is_store(req_op);
            addr_d = {req_addr[31:2], 2'b00};
            be_d   = op_is_load(req_op) ? BE_WORD : store_byteenable(req_op, req_addr[1:0]);
            wd_d   = store_data(req_op, req_wdata);
          end
        end
      end
      // Rejected requests still pass one idle-bus cycle here so every request
      // sees the same minimum request-to-done latency.
      ST_ACCESS: begin
        if (err_q) begin
          state_d = ST_RESP;
        end else if (!mem_waitrequest) begin
          state_d = ST_RESP;
          rdata_d = op_is_load(op_q) ? align_result : '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          be_d    = BE_NONE;
          addr_d  = '0;
          wd_d    = '0;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      k_q     <= '0;
      rt_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= BE_NONE;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      k_q     <= k_d;
      rt_q    <= rt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_RESP);
  assign rdata          = rdata_q;
  assign addr_err       = err_q;
  assign mem_address    = addr_q;
  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wd_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a byte-level reference model.
module tb_mem_access_ctrl;

`ifdef UNALIGNED_LWL_LWR_EN
  localparam bit LWLR = 1'b1;
`else
  localparam bit LWLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_rt = '0;
  logic        busy, done, addr_err;
  logic [31:0] rdata, mem_address, mem_writedata;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata = '0;
  logic        mem_waitrequest = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_accepted = 0;

  mem_access_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_rt          (req_rt),
    .busy            (busy),
    .done            (done),
    .rdata           (rdata),
    .addr_err        (addr_err),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) n_done++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: works on byte arrays and plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rt,
                                input logic [31:0] rd, output bit err, output bit is_ld,
                                output bit is_st, output logic [31:0] x_rdata,
                                output logic [3:0] x_be, output logic [31:0] x_wd);
    int oi;
    int k;
    int size;
    int v;
    byte unsigned m[4];
    byte unsigned r[4];
    byte unsigned w[4];
    byte unsigned res[4];
    oi = int'(op);
    k = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) begin
      m[i] = rd[8*i +: 8];
      r[i] = rt[8*i +: 8];
      w[i] = wdata[8*i +: 8];
      res[i] = r[i];
    end
    is_ld = (oi <= 6);
    is_st = (oi >= 7 && oi <= 9);
    size = (oi == 0 || oi == 1 || oi == 7) ? 1 : (oi == 2 || oi == 3 || oi == 8) ? 2 : 4;
    err = !(is_ld || is_st);
    if ((oi == 5 || oi == 6) && !LWLR) err = 1;
    if ((oi == 2 || oi == 3 || oi == 8) && (k % 2) != 0) err = 1;
    if ((oi == 4 || oi == 9) && k != 0) err = 1;
    x_rdata = '0;
    x_be = 4'h0;
    x_wd = '0;
    if (err) begin
      is_ld = 0;
      is_st = 0;
      return;
    end
    if (is_st) begin
      x_be = 4'(((1 << size) - 1) << k);
      for (int i = 0; i < 4; i++) x_wd[8*i +: 8] = w[i % size];
      return;
    end
    x_be = 4'hF;
    case (oi)
      0, 1: begin
        v = m[k];
        if (oi == 0 && v >= 128) v = v - 256;
        x_rdata = 32'(v);
      end
      2, 3: begin
        v = m[k] + 256 * m[k+1];
        if (oi == 2 && v >= 32768) v = v - 65536;
        x_rdata = 32'(v);
      end
      4: x_rdata = rd;
      5: begin
        for (int i = 0; i <= k; i++) res[3-k+i] = m[i];
        x_rdata = {res[3], res[2], res[1], res[0]};
      end
      default: begin
        for (int i = k; i <= 3; i++) res[i-k] = m[i];
        x_rdata = {res[3], res[2], res[1], res[0]};
      end
    endcase
  endfunction

  task automatic run_req(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rt, input logic [31:0] rd,
                         input int wt, input bit junk, output logic [31:0] got_rdata,
                         output logic got_err);
    bit e, ld, st, seen;
    logic [31:0] xr, xwd;
    logic [3:0] xbe;
    int rem, lat;
    model(op, addr, wdata, rt, rd, e, ld, st, xr, xbe, xwd);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wdata;
    req_rt = rt;
    rem = wt;
    seen = 0;
    lat = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        lat = c;
      end else begin
        check_eq({tag, ":busy"}, 32'(busy), 32'd1);
        if (e) begin
          check_eq({tag, ":no_bus"}, 32'({mem_read, mem_write}), 32'd0);
        end else begin
          check_eq({tag, ":rd_wr"}, 32'({mem_read, mem_write}), 32'({ld, st}));
          check_eq({tag, ":addr"}, mem_address, {addr[31:2], 2'b00});
          check_eq({tag, ":be"}, 32'(mem_byteenable), 32'(xbe));
          if (st) check_eq({tag, ":wdata"}, mem_writedata, xwd);
        end
        mem_waitrequest = (rem > 0);
        if (rem > 0) rem--;
        mem_readdata = mem_waitrequest ? $urandom : rd;
        if (junk) begin
          req_valid = 1'($urandom_range(0, 1));
          req_op = 4'($urandom_range(0, 11));
          req_addr = $urandom;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    mem_waitrequest = 1'b0;
    check_eq({tag, ":done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, ":latency"}, 32'(lat), e ? 32'd2 : 32'(2 + wt));
    check_eq({tag, ":rdata"}, rdata, xr);
    check_eq({tag, ":addr_err"}, 32'(addr_err), 32'(e));
    check_eq({tag, ":bus_idle_at_done"}, 32'({mem_read, mem_write}), 32'd0);
    got_rdata = rdata;
    got_err = addr_err;
    n_accepted++;
    @(negedge clk);
    check_eq({tag, ":done_one_cycle"}, 32'(done), 32'd0);
    check_eq({tag, ":idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic er;
    repeat (3) @(negedge clk);
    check_eq("rst:busy", 32'(busy), 32'd0);
    check_eq("rst:done", 32'(done), 32'd0);
    check_eq("rst:rd_wr", 32'({mem_read, mem_write}), 32'd0);
    check_eq("rst:be", 32'(mem_byteenable), 32'd0);
    check_eq("rst:addr", mem_address, 32'd0);
    check_eq("rst:rdata", rdata, 32'd0);
    check_eq("rst:addr_err", 32'(addr_err), 32'd0);
    reset = 1'b0;

    run_req("lb", 4'd0, 32'h0000_1003, 32'h0, 32'h0, 32'h80AB_CD12, 0, 0, r, er);
    check_eq("lb:const_rdata", r, 32'hFFFF_FF80);
    check_eq("lb:const_err", 32'(er), 32'd0);

    run_req("sh", 4'd8, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 32'h1234_5678, 3, 0, r, er);
    check_eq("sh:const_rdata", r, 32'd0);

    run_req("lw_mis", 4'd4, 32'h0000_3001, 32'h0, 32'h0, 32'h5555_5555, 2, 0, r, er);
    check_eq("lw_mis:const_err", 32'(er), 32'd1);
    check_eq("lw_mis:const_rdata", r, 32'd0);

    run_req("lwl", 4'd5, 32'h0000_4001, 32'h0, 32'hAAAA_AAAA, 32'h4433_2211, 0, 0, r, er);
    check_eq("lwl:const_rdata", r, LWLR ? 32'h2211_AAAA : 32'd0);
    check_eq("lwl:const_err", 32'(er), LWLR ? 32'd0 : 32'd1);

    run_req("busy_pulse", 4'd1, 32'h0000_6002, 32'h0, 32'h0, 32'hCAFE_F00D, 2, 1, r, er);

    // Abort a waiting read with reset: bus drops, no done for it.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 4'd4;
    req_addr = 32'h0000_5000;
    mem_waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort:read_high", 32'(mem_read), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort:read_low", 32'(mem_read), 32'd0);
    check_eq("abort:busy", 32'(busy), 32'd0);
    check_eq("abort:done", 32'(done), 32'd0);
    check_eq("abort:addr", mem_address, 32'd0);
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("abort:no_late_done", 32'(done), 32'd0);
    end
    run_req("after_abort", 4'd4, 32'h0000_5004, 32'h0, 32'h0, 32'h0BAD_F00D, 1, 0, r, er);
    check_eq("after_abort:const_rdata", r, 32'h0BAD_F00D);

    for (int i = 0; i < 250; i++) begin
      run_req("rand", 4'($urandom_range(0, 11)), $urandom, $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r, er);
    end

    @(negedge clk);
    check_eq("done_count", 32'(n_done), 32'(n_accepted));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
